// File: rtl/lcd_name_writer.sv
// HD44780 8-bit bus writer: runs the panel power-on init after reset, then on
// request copies a 16-character exercise name from the name ROM onto line 1.
module lcd_name_writer #(
  parameter int         PWR_WAIT_CYC = 1000000,
  parameter int         E_HIGH_CYC   = 25,
  parameter int         CMD_WAIT_CYC = 2500,
  parameter int         CLR_WAIT_CYC = 100000,
  parameter logic [7:0] LINE_ADDR    = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exercise_id,
  output logic       busy,
  output logic       done,
  output logic [3:0] rom_exercise_id,
  output logic [4:0] rom_char_index,
  input  logic [7:0] rom_ascii_char,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT, S_IDLE, S_SET_ADDR, S_FETCH, S_WRITE, S_FINISH
  } state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_E_HIGH, PH_HOLD} phase_e;
  typedef enum logic [1:0] {SEQ_INIT, SEQ_ADDR, SEQ_CHAR} seq_e;

  localparam logic [31:0] PWR_LAST = 32'(PWR_WAIT_CYC - 1);
  localparam logic [31:0] E_LAST   = 32'(E_HIGH_CYC - 1);
  localparam logic [31:0] CMD_WAIT = 32'(CMD_WAIT_CYC);
  localparam logic [31:0] CLR_WAIT = 32'(CLR_WAIT_CYC);

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      2'd3:    init_cmd = 8'h06;
      default: init_cmd = 8'h38;
    endcase
  endfunction

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  seq_e        seq_q, seq_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_q, wait_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  rom_id_q, rom_id_d;
  logic [4:0]  rom_idx_q, rom_idx_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_rw_q, lcd_rw_d;
  logic        lcd_e_q, lcd_e_d;
  logic [7:0]  lcd_data_q, lcd_data_d;

  // Next-state and next-output logic; every write funnels through S_WRITE.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    seq_d      = seq_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    init_idx_d = init_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rom_id_d   = rom_id_q;
    rom_idx_d  = rom_idx_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_rw_d   = 1'b0;
    lcd_e_d    = lcd_e_q;
    lcd_data_d = lcd_data_q;

    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d    = S_INIT;
          cnt_d      = 32'd0;
          init_idx_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_INIT: begin
        lcd_data_d = init_cmd(init_idx_q);
        lcd_rs_d   = 1'b0;
        wait_d     = (init_cmd(init_idx_q) == 8'h01) ? CLR_WAIT : CMD_WAIT;
        seq_d      = SEQ_INIT;
        state_d    = S_WRITE;
        phase_d    = PH_SETUP;
        cnt_d      = 32'd0;
      end
      S_IDLE: begin
        if (start) begin
          rom_id_d = exercise_id;
          busy_d   = 1'b1;
          state_d  = S_SET_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SET_ADDR: begin
        lcd_data_d = LINE_ADDR;
        lcd_rs_d   = 1'b0;
        wait_d     = CMD_WAIT;
        seq_d      = SEQ_ADDR;
        rom_idx_d  = 5'd0;
        state_d    = S_WRITE;
        phase_d    = PH_SETUP;
        cnt_d      = 32'd0;
      end
      S_FETCH: begin
        lcd_data_d = rom_ascii_char;
        lcd_rs_d   = 1'b1;
        wait_d     = CMD_WAIT;
        seq_d      = SEQ_CHAR;
        state_d    = S_WRITE;
        phase_d    = PH_SETUP;
        cnt_d      = 32'd0;
      end
      S_WRITE: begin
        case (phase_q)
          PH_SETUP: begin
            lcd_e_d = 1'b1;
            phase_d = PH_E_HIGH;
            cnt_d   = 32'd0;
          end
          PH_E_HIGH: begin
            if (cnt_q == E_LAST) begin
              lcd_e_d = 1'b0;
              phase_d = PH_HOLD;
              cnt_d   = 32'd0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          PH_HOLD: begin
            if (cnt_q == wait_q - 32'd1) begin
              cnt_d = 32'd0;
              // Pick the follow-on step from which sequence issued this write.
              case (seq_q)
                SEQ_INIT: begin
                  if (init_idx_q == 2'd3) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                  end else begin
                    init_idx_d = init_idx_q + 2'd1;
                    state_d    = S_INIT;
                  end
                end
                SEQ_ADDR: state_d = S_FETCH;
                SEQ_CHAR: begin
                  if (rom_idx_q == 5'd15) begin
                    state_d = S_FINISH;
                  end else begin
                    rom_idx_d = rom_idx_q + 5'd1;
                    state_d   = S_FETCH;
                  end
                end
                default: state_d = S_IDLE;
              endcase
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          default: begin
            lcd_e_d = 1'b0;
            phase_d = PH_SETUP;
          end
        endcase
      end
      S_FINISH: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        lcd_rs_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_PWR_WAIT;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PWR_WAIT;
      phase_q    <= PH_SETUP;
      seq_q      <= SEQ_INIT;
      cnt_q      <= 32'd0;
      wait_q     <= 32'd0;
      init_idx_q <= 2'd0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      rom_id_q   <= 4'd0;
      rom_idx_q  <= 5'd0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      init_idx_q <= init_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_id_q   <= rom_id_d;
      rom_idx_q  <= rom_idx_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_rw_q   <= lcd_rw_d;
      lcd_e_q    <= lcd_e_d;
      lcd_data_q <= lcd_data_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rom_exercise_id = rom_id_q;
  assign rom_char_index  = rom_idx_q;
  assign lcd_rs          = lcd_rs_q;
  assign lcd_rw          = lcd_rw_q;
  assign lcd_e           = lcd_e_q;
  assign lcd_data        = lcd_data_q;

endmodule

// File: tb/tb_lcd_name_writer.sv
// Scoreboard bench for lcd_name_writer: expected LCD writes are queued when
// stimulus is issued and a monitor checks each lcd_e pulse and its timing.
module tb_lcd_name_writer;

  localparam int PWR = 20;
  localparam int EH  = 2;
  localparam int CW  = 5;
  localparam int CLW = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] exercise_id;
  logic       busy;
  logic       done;
  logic [3:0] rom_exercise_id;
  logic [4:0] rom_char_index;
  logic [7:0] rom_ascii_char;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  lcd_name_writer #(
    .PWR_WAIT_CYC(PWR),
    .E_HIGH_CYC  (EH),
    .CMD_WAIT_CYC(CW),
    .CLR_WAIT_CYC(CLW),
    .LINE_ADDR   (8'h80)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .exercise_id    (exercise_id),
    .busy           (busy),
    .done           (done),
    .rom_exercise_id(rom_exercise_id),
    .rom_char_index (rom_char_index),
    .rom_ascii_char (rom_ascii_char),
    .lcd_rs         (lcd_rs),
    .lcd_rw         (lcd_rw),
    .lcd_e          (lcd_e),
    .lcd_data       (lcd_data)
  );

  string names [0:9] = '{"Squats", "Jumping Jacks", "Push-Ups", "Lunges", "Plank",
                         "Mountain Climb", "Burpees", "Sit-Ups", "High Knees", "Crunches"};

  // Name ROM: unknown ids and positions past the name read as spaces.
  function automatic logic [7:0] rom_char(input logic [3:0] id, input logic [4:0] idx);
    string s;
    if (id > 4'd9 || idx > 5'd15) return 8'h20;
    s = names[id];
    if (int'(idx) < s.len()) return s[int'(idx)];
    return 8'h20;
  endfunction

  assign rom_ascii_char = rom_char(rom_exercise_id, rom_char_index);

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wt;
  } wr_t;

  wr_t sb[$];
  int  done_pend = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic rs_v, input logic [7:0] d, input int wt);
    wr_t w;
    w.rs = rs_v; w.data = d; w.wt = wt;
    sb.push_back(w);
  endtask

  task automatic push_init();
    push_wr(1'b0, 8'h38, CW);
    push_wr(1'b0, 8'h0C, CW);
    push_wr(1'b0, 8'h01, CLW);
    push_wr(1'b0, 8'h06, CW);
  endtask

  task automatic push_name(input logic [3:0] id);
    push_wr(1'b0, 8'h80, CW);
    for (int i = 0; i < 16; i++) push_wr(1'b1, rom_char(id, 5'(i)), CW);
  endtask

  // Monitor: checks every pulse against the queue, pulse width, setup and hold.
  initial begin : monitor
    logic       prev_e, p_rs, prev_rs, stable_ok;
    logic [7:0] p_data, prev_data;
    int         high_cnt, hold_left, cur_wait;
    wr_t        cur;
    prev_e = 1'b0; prev_rs = 1'b0; prev_data = 8'h00; p_rs = 1'b0; p_data = 8'h00;
    stable_ok = 1'b1; high_cnt = 0; hold_left = 0; cur_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_e = 1'b0; high_cnt = 0; hold_left = 0;
      end else begin
        if (lcd_e && !prev_e) begin
          check("hold_complete_before_rise", hold_left, 0);
          hold_left = 0;
          check("setup_stable", {prev_rs, prev_data}, {lcd_rs, lcd_data});
          check("lcd_rw_low", lcd_rw, 0);
          check("pulse_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            check("pulse_rs", lcd_rs, cur.rs);
            check("pulse_data", lcd_data, cur.data);
            cur_wait = cur.wt;
          end
          p_rs = lcd_rs; p_data = lcd_data; high_cnt = 1; stable_ok = 1'b1;
        end else if (lcd_e && prev_e) begin
          high_cnt++;
          if ({lcd_rs, lcd_data} != {p_rs, p_data}) stable_ok = 1'b0;
        end else if (!lcd_e && prev_e) begin
          check("e_high_len", high_cnt, EH);
          hold_left = cur_wait;
        end
        if (!lcd_e && hold_left > 0) begin
          if ({lcd_rs, lcd_data} != {p_rs, p_data}) stable_ok = 1'b0;
          hold_left--;
          if (hold_left == 0) check("data_rs_stable_thru_hold", stable_ok, 1);
        end
        if (done) begin
          check("done_expected", done_pend > 0, 1);
          check("done_after_all_writes", sb.size(), 0);
          if (done_pend > 0) done_pend--;
        end
        prev_e = lcd_e; prev_rs = lcd_rs; prev_data = lcd_data;
      end
    end
  end

  task automatic pulse_start(input logic [3:0] id);
    @(posedge clk); #1;
    start = 1'b1; exercise_id = id;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_size(input int n);
    int c = 0;
    while (sb.size() > n && c < 5000) begin
      @(negedge clk); #1; c++;
    end
    check("wait_size_timeout", c < 5000, 1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((sb.size() != 0 || done_pend != 0) && c < 5000) begin
      @(negedge clk); #1; c++;
    end
    check("wait_idle_timeout", c < 5000, 1);
    repeat (CLW + 5) @(negedge clk);
    check("busy_low_when_idle", busy, 0);
  endtask

  task automatic name_write(input logic [3:0] id, input bit disturb, input logic [3:0] alt);
    push_name(id);
    done_pend++;
    pulse_start(id);
    if (disturb) begin
      wait_size(10);
      check("busy_mid_write", busy, 1);
      pulse_start(alt);
    end
    wait_idle();
    check("rom_id_held", rom_exercise_id, id);
    check("rom_idx_final", rom_char_index, 15);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    rst = 1'b1; start = 1'b0; exercise_id = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_rw", lcd_rw, 0);
    check("rst_lcd_data", lcd_data, 0);
    check("rst_rom_id", rom_exercise_id, 0);
    check("rst_rom_idx", rom_char_index, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 1);

    @(posedge clk); #1;
    rst = 1'b0;
    push_init();
    c = 0;
    @(negedge clk);
    while (lcd_e == 1'b0 && c < 500) begin
      c++;
      @(negedge clk);
    end
    check("pwr_wait_timeout", c < 500, 1);
    check("pwr_quiet_cycles", c >= PWR, 1);

    wait_size(2);
    check("busy_during_init", busy, 1);
    pulse_start(4'($urandom_range(0, 15)));
    wait_idle();

    name_write(4'd2, 1'b1, 4'd9);
    name_write(4'd5, 1'b0, 4'd0);
    name_write(4'd12, 1'b1, 4'd9);
    for (int k = 0; k < 4; k++)
      name_write(4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)));

    // Abort a write while lcd_e is high on character 7.
    push_name(4'd3);
    done_pend++;
    pulse_start(4'd3);
    wait_size(8);
    check("e_high_at_abort", lcd_e, 1);
    rst = 1'b1;
    sb.delete();
    done_pend = 0;
    @(negedge clk);
    check("abort_lcd_e", lcd_e, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    push_init();
    wait_idle();
    name_write(4'd2, 1'b0, 4'd0);

    check("final_queue_empty", sb.size(), 0);
    check("final_done_pending", done_pend, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
